// File: rtl/div_pkg.sv
// Shared constants and encodings for the RV32M iterative divider.
// Pure definitions; no timing or handshake of its own.
package div_pkg;
    localparam int XLEN = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: brings in the next dividend bit and emits one quotient bit.
// Combinational, zero latency; no flow control.
module div_step import div_pkg::*; #(
    parameter int W = XLEN
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor_mag,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);
    logic [W:0] shifted;
    logic [W:0] trial;
    logic       borrow;

    // The shifted partial remainder can use all W+1 bits, so the borrow needs one bit more.
    always_comb begin
        shifted           = {rem_in, bit_in};
        {borrow, trial}   = {1'b0, shifted} - {2'b00, divisor_mag};
        q_bit             = ~borrow;
        rem_out           = borrow ? shifted[W-1:0] : trial[W-1:0];
    end
endmodule

// File: rtl/iterative_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: one quotient bit per clock, done pulse 33 cycles after start.
// busy holds off new starts; DIV_FAST_SPECIAL_EN finishes x/0, overflow and x/1 in one cycle.
module iterative_divider #(
    parameter int XLEN  = div_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import div_pkg::*;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

    state_t           state;
    logic [1:0]       op_q;
    logic [XLEN-1:0]  rem_acc;
    logic [XLEN-1:0]  quo;
    logic [XLEN-1:0]  divisor_mag;
    logic [CNT_W-1:0] cnt;
    logic             neg_quo;
    logic             neg_rem;
    logic             div_zero;
    logic             overflow;

    logic             signed_op;
    logic [XLEN-1:0]  dividend_abs;
    logic [XLEN-1:0]  divisor_abs;
    logic             in_zero;
    logic             in_ovf;
    logic             take_fast;

    logic [XLEN-1:0]  step_rem;
    logic             step_q;
    logic [XLEN-1:0]  quo_fix;
    logic [XLEN-1:0]  rem_fix;

    always_comb begin
        signed_op    = (op == OP_DIV) || (op == OP_REM);
        dividend_abs = (signed_op && dividend[XLEN-1]) ? -dividend : dividend;
        divisor_abs  = (signed_op && divisor[XLEN-1])  ? -divisor  : divisor;
        in_zero      = (divisor == '0);
        in_ovf       = signed_op && (dividend == MIN_NEG) && (divisor == '1);
    end

`ifdef DIV_FAST_SPECIAL_EN
    assign take_fast = in_zero || in_ovf || (divisor == XLEN'(1));
`else
    assign take_fast = 1'b0;
`endif

    div_step #(.W(XLEN)) u_step (
        .rem_in      (rem_acc),
        .bit_in      (quo[XLEN-1]),
        .divisor_mag (divisor_mag),
        .rem_out     (step_rem),
        .q_bit       (step_q)
    );

    // Magnitudes in quo/rem_acc already give the dividend as remainder for x/0; only the quotient needs overriding.
    always_comb begin
        quo_fix = neg_quo ? -quo : quo;
        rem_fix = neg_rem ? -rem_acc : rem_acc;
        if (div_zero) begin
            quo_fix = '1;
        end else if (overflow) begin
            quo_fix = MIN_NEG;
            rem_fix = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            op_q        <= 2'b00;
            rem_acc     <= '0;
            quo         <= '0;
            divisor_mag <= '0;
            cnt         <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            div_zero    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q        <= op;
                        quo         <= dividend_abs;
                        divisor_mag <= divisor_abs;
                        neg_quo     <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                        neg_rem     <= signed_op && dividend[XLEN-1];
                        div_zero    <= in_zero;
                        overflow    <= in_ovf;
                        cnt         <= '0;
                        // Fast cases skip the datapath: FIX sees quo=|dividend|, rem_acc preloaded.
                        rem_acc     <= (take_fast && in_zero) ? dividend_abs : '0;
                        state       <= take_fast ? S_FIX : S_CALC;
                        busy        <= ~take_fast;
                    end
                end
                S_CALC: begin
                    rem_acc <= step_rem;
                    quo     <= {quo[XLEN-2:0], step_q};
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state  <= S_IDLE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= op_q[1] ? rem_fix : quo_fix;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
